// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small character FIFO.
// Frame settings are captured per character when it leaves the FIFO.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int KW    = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic [KW-1:0]            k,
    input  logic [1:0]               data_bits,
    input  logic                     parity_en,
    input  logic                     odd,
    input  logic                     two_stop,
    output logic                     tx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic [KW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [2:0]    r_last;
    logic [7:0]    r_char;
    logic          r_par_en;
    logic          r_odd;
    logic          r_two;
    logic          r_second;
    logic          r_tx;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic          w_frame_end;
    logic [7:0]    w_mask;
    logic          w_parity;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign w_push      = wr_en && !w_full;
    assign w_tick      = (r_cnt == k);
    assign w_frame_end = (r_state == STOP) && w_tick && (!r_two || r_second);
    // The line pulls the next character either from idle or straight off the last stop bit.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign w_mask      = 8'hFF >> (3'd7 - r_last);
    assign w_parity    = (^(r_char & w_mask)) ^ r_odd;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= wr_en && w_full;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_last   <= '0;
            r_char   <= '0;
            r_par_en <= 1'b0;
            r_odd    <= 1'b0;
            r_two    <= 1'b0;
            r_second <= 1'b0;
        end else begin
            if (r_state != IDLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_tx    <= r_char[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit == r_last) begin
                            r_second <= 1'b0;
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= w_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_char[r_bit + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state  <= STOP;
                        r_second <= 1'b0;
                        r_tx     <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_two && !r_second) begin
                            r_second <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
            // A pop overrides whatever the case chose: load the next frame.
            if (w_pop) begin
                r_state  <= START;
                r_tx     <= 1'b0;
                r_cnt    <= '0;
                r_bit    <= '0;
                r_second <= 1'b0;
                r_char   <= r_mem[r_rptr];
                r_last   <= {1'b0, data_bits} + 3'd4;
                r_par_en <= parity_en;
                r_odd    <= odd;
                r_two    <= two_stop;
            end
        end
    end

    assign tx       = r_tx;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner cases and
// randomized batches against a frame-level reference model.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [18:0] k;
    logic [1:0]  data_bits;
    logic        parity_en;
    logic        odd;
    logic        two_stop;
    logic        tx;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        busy;
    logic        overflow;

    uart_tx_fifo #(.DEPTH(8), .KW(19)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .k         (k),
        .data_bits (data_bits),
        .parity_en (parity_en),
        .odd       (odd),
        .two_stop  (two_stop),
        .tx        (tx),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cap[$];
    bit exq[$];

    typedef struct {
        logic [18:0] kk;
        logic [1:0]  db;
        logic        pe;
        logic        od;
        logic        ts;
        logic [7:0]  c;
        string       bits;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cap.push_back(tx);
    endtask

    // Expected line samples for one character, one entry per clock.
    task automatic add_frame(input logic [7:0] c, input logic [1:0] db,
                             input logic pe, input logic od,
                             input logic ts, input int kk);
        int nb;
        bit p;
        bit bits[$];
        nb = int'(db) + 5;
        p  = od;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(c[i]);
            p ^= c[i];
        end
        if (pe) bits.push_back(p);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[i]) repeat (kk + 1) exq.push_back(bits[i]);
    endtask

    task automatic start_write(input logic [7:0] c, input string name);
        wr_en   = 1'b1;
        wr_data = c;
        @(posedge clk);
        #1;
        chk({name, " tx_on_accept_edge"}, tx, 1);
        cap.delete();
        exq.delete();
    endtask

    task automatic check_stream(input string name);
        int first;
        first = -1;
        while (cap.size() < exq.size() + 1) tick();
        for (int i = 0; i < exq.size(); i++)
            if (first < 0 && cap[i] != exq[i]) first = i;
        chk({name, " first_bad_sample"}, 32'(first), 32'hFFFF_FFFF);
        chk({name, " end_tx"}, tx, 1);
        chk({name, " end_busy"}, busy, 0);
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic pe,
                           input logic od, input logic ts);
        data_bits = db;
        parity_en = pe;
        odd       = od;
        two_stop  = ts;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] acc[$];
        logic [7:0] mq[$];
        logic [7:0] cs[$];
        int         peak;
        int         zeros;
        int         n;
        logic [1:0] db1;
        logic [1:0] db2;
        logic       pe1, od1, ts1, pe2, od2, ts2;
        logic       exp_ovf;

        tbl[0] = '{19'd3, 2'b11, 1'b0, 1'b0, 1'b0, 8'h55, "0101010101"};
        tbl[1] = '{19'd0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h41, "0100000101"};
        tbl[2] = '{19'd1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h1F, "011111011"};
        tbl[3] = '{19'd2, 2'b01, 1'b1, 1'b0, 1'b1, 8'h2D, "0101101011"};
        tbl[4] = '{19'd0, 2'b11, 1'b1, 1'b1, 1'b1, 8'hA3, "011000101111"};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        k       = 19'd0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        #23;
        chk("rst tx", tx, 1);
        chk("rst level", level, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst busy", busy, 0);
        chk("rst overflow", overflow, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("post-rst idle tx", tx, 1);
        chk("post-rst idle busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            k = tbl[v].kk;
            set_cfg(tbl[v].db, tbl[v].pe, tbl[v].od, tbl[v].ts);
            start_write(tbl[v].c, $sformatf("vec%0d", v));
            wr_en = 1'b0;
            for (int j = 0; j < tbl[v].bits.len(); j++)
                repeat (int'(tbl[v].kk) + 1)
                    exq.push_back(tbl[v].bits[j] == "1");
            check_stream($sformatf("vec%0d", v));
        end

        // Ten back-to-back writes into an idle line.
        k = 19'd0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        acc.delete();
        mq.delete();
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            c       = 8'($urandom);
            wr_en   = 1'b1;
            wr_data = c;
            exp_ovf = (mq.size() == 8);
            if (!exp_ovf) begin
                mq.push_back(c);
                acc.push_back(c);
            end
            if (i == 1) void'(mq.pop_front());
            if (i == 0) begin
                @(posedge clk);
                #1;
                cap.delete();
                exq.delete();
            end else begin
                tick();
            end
            if (int'(level) > peak) peak = int'(level);
            chk($sformatf("burst%0d level", i), level, mq.size());
            chk($sformatf("burst%0d full", i), full, mq.size() == 8);
            chk($sformatf("burst%0d overflow", i), overflow, exp_ovf);
        end
        wr_en = 1'b0;
        tick();
        chk("burst overflow one cycle", overflow, 0);
        chk("burst peak level", peak, 8);
        chk("burst accepted", acc.size(), 9);
        foreach (acc[i]) add_frame(acc[i], 2'b11, 1'b0, 1'b0, 1'b0, 0);
        check_stream("burst");

        // Reset in the middle of frame 2 of 3.
        k = 19'd1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        start_write(8'h3C, "rstmid");
        wr_data = 8'h00;
        tick();
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        while (cap.size() < 27) tick();
        chk("rstmid tx before rst", tx, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid tx", tx, 1);
        chk("rstmid level", level, 0);
        chk("rstmid empty", empty, 1);
        chk("rstmid full", full, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid overflow", overflow, 0);
        tick();
        tick();
        rst = 1'b0;
        cap.delete();
        repeat (40) tick();
        zeros = 0;
        foreach (cap[i]) if (!cap[i]) zeros++;
        chk("rstmid no resend", zeros, 0);
        chk("rstmid idle busy", busy, 0);
        start_write(8'h96, "rstnew");
        wr_en = 1'b0;
        add_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        check_stream("rstnew");

        // Width change while a frame is on the line.
        k = 19'd0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        start_write(8'hC6, "dbchg");
        wr_en = 1'b0;
        repeat (3) tick();
        data_bits = 2'b00;
        wr_en     = 1'b1;
        wr_data   = 8'hF3;
        tick();
        wr_en = 1'b0;
        add_frame(8'hC6, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        add_frame(8'hF3, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        check_stream("dbchg");

        // Random batches; config switches after the first frame is latched.
        for (int it = 0; it < 6; it++) begin
            n   = $urandom_range(1, 6);
            k   = 19'($urandom_range(0, 2));
            db1 = 2'($urandom);
            pe1 = 1'($urandom);
            od1 = 1'($urandom);
            ts1 = 1'($urandom);
            db2 = 2'($urandom);
            pe2 = 1'($urandom);
            od2 = 1'($urandom);
            ts2 = 1'($urandom);
            cs.delete();
            for (int i = 0; i < n; i++) cs.push_back(8'($urandom));
            set_cfg(db1, pe1, od1, ts1);
            start_write(cs[0], $sformatf("rnd%0d", it));
            for (int i = 1; i < n; i++) begin
                wr_data = cs[i];
                tick();
            end
            wr_en = 1'b0;
            tick();
            set_cfg(db2, pe2, od2, ts2);
            add_frame(cs[0], db1, pe1, od1, ts1, int'(k));
            for (int i = 1; i < n; i++)
                add_frame(cs[i], db2, pe2, od2, ts2, int'(k));
            check_stream($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
